bcd_digit_counter: RTL and testbench

//  4-digit BCD counter with built-in clock prescaler; the stage directly upstream of the
//  7-segment decoder. Each 4-bit digit output connects straight to a decoder's iDIG input.

---
 rtl/bcd_digit_counter.sv | 110 +++++++++++
 tb/tb_bcd_digit_counter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_counter.sv
// 4-digit BCD counter with prescaler, feeding 7-segment decoders.
// Ports: iCLK, iRST_N (sync, active-low), iEN, iCLR, iLOAD, iDATA[15:0],
//   iDIR (only with BCD_DOWN_EN), oDIG0..oDIG3, oTICK, oCARRY.
// Macro BCD_DOWN_EN adds iDIR and down-counting.
module bcd_digit_counter #(
  parameter int DIV   = 50_000_000,
  parameter int DIV_W = 26
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iEN,
  input  logic        iCLR,
  input  logic        iLOAD,
  input  logic [15:0] iDATA,
`ifdef BCD_DOWN_EN
  input  logic        iDIR,
`endif
  output logic [3:0]  oDIG0,
  output logic [3:0]  oDIG1,
  output logic [3:0]  oDIG2,
  output logic [3:0]  oDIG3,
  output logic        oTICK,
  output logic        oCARRY
);

  logic [DIV_W-1:0] pre;
  logic             step;
  logic             dn;
  logic             wrap;
  logic [3:0][3:0]  dq;
  logic [3:0][3:0]  dd;
  logic [3:0][3:0]  ld;

`ifdef BCD_DOWN_EN
  assign dn = iDIR;
`else
  assign dn = 1'b0;
`endif

  assign step = iEN && (pre == DIV_W'(DIV - 1));

  // Out-of-range nibbles load as zero so digits stay valid BCD.
  always_comb begin
    ld = '0;
    for (int i = 0; i < 4; i++) begin
      ld[i] = (iDATA[4*i +: 4] > 4'd9) ? 4'd0 : iDATA[4*i +: 4];
    end
  end

  // Ripple carry/borrow across digits; wrap is the carry out of digit 3.
  always_comb begin
    logic c;
    c  = 1'b1;
    dd = dq;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (dn) begin
          if (dq[i] == 4'd0) begin
            dd[i] = 4'd9;
          end else begin
            dd[i] = dq[i] - 4'd1;
            c     = 1'b0;
          end
        end else begin
          if (dq[i] >= 4'd9) begin
            dd[i] = 4'd0;
          end else begin
            dd[i] = dq[i] + 4'd1;
            c     = 1'b0;
          end
        end
      end
    end
    wrap = c;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      pre    <= '0;
      dq     <= '0;
      oTICK  <= 1'b0;
      oCARRY <= 1'b0;
    end else if (iCLR) begin
      pre    <= '0;
      dq     <= '0;
      oTICK  <= 1'b0;
      oCARRY <= 1'b0;
    end else if (iLOAD) begin
      pre    <= '0;
      dq     <= ld;
      oTICK  <= 1'b0;
      oCARRY <= 1'b0;
    end else begin
      oTICK  <= step;
      oCARRY <= step && wrap;
      if (step) begin
        pre <= '0;
        dq  <= dd;
      end else if (iEN) begin
        pre <= pre + DIV_W'(1);
      end
    end
  end

  assign oDIG0 = dq[0];
  assign oDIG1 = dq[1];
  assign oDIG2 = dq[2];
  assign oDIG3 = dq[3];

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Bench for bcd_digit_counter (DIV=4): integer-value model
// checked every cycle plus hand-computed literal points.
module tb_bcd_digit_counter;

  localparam int DIV = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic        load;
  logic [15:0] data;
  logic        dir;
  logic [3:0]  d0, d1, d2, d3;
  logic        tick, carry;

  int checks;
  int failures;
  bit chk_on;

  int mval;
  int mpre;
  bit mtick;
  bit mcarry;

  bcd_digit_counter #(.DIV(DIV), .DIV_W(3)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .iEN    (en),
    .iCLR   (clr),
    .iLOAD  (load),
    .iDATA  (data),
`ifdef BCD_DOWN_EN
    .iDIR   (dir),
`endif
    .oDIG0  (d0),
    .oDIG1  (d1),
    .oDIG2  (d2),
    .oDIG3  (d3),
    .oTICK  (tick),
    .oCARRY (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  function automatic int load_val(input logic [15:0] x);
    int v;
    int w;
    int n;
    v = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      n = int'(x[4*i +: 4]);
      if (n > 9) n = 0;
      v += n * w;
      w *= 10;
    end
    return v;
  endfunction

  // Model: the count is a plain integer 0..9999.
  always @(posedge clk) begin
    bit down;
`ifdef BCD_DOWN_EN
    down = dir;
`else
    down = 1'b0;
`endif
    if (!rst_n || clr) begin
      mval = 0; mpre = 0; mtick = 0; mcarry = 0;
    end else if (load) begin
      mval = load_val(data); mpre = 0; mtick = 0; mcarry = 0;
    end else if (en && mpre == DIV - 1) begin
      mpre  = 0;
      mtick = 1;
      if (down) begin
        mcarry = (mval == 0);
        mval   = (mval + 9999) % 10000;
      end else begin
        mcarry = (mval == 9999);
        mval   = (mval + 1) % 10000;
      end
    end else begin
      if (en) mpre = mpre + 1;
      mtick = 0; mcarry = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if ({d3, d2, d1, d0, tick, carry} !== {to_bcd(mval), mtick, mcarry}) begin
        failures++;
        $display("FAIL cycle_model t=%0t got dig=%h tick=%b carry=%b want dig=%h tick=%b carry=%b",
                 $time, {d3, d2, d1, d0}, tick, carry, to_bcd(mval), mtick, mcarry);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string nm, input logic [15:0] ed, input logic et, input logic ec);
    checks++;
    if ({d3, d2, d1, d0, tick, carry} !== {ed, et, ec}) begin
      failures++;
      $display("FAIL %s got dig=%h tick=%b carry=%b want dig=%h tick=%b carry=%b",
               nm, {d3, d2, d1, d0}, tick, carry, ed, et, ec);
    end
    checks++;
    if ({to_bcd(mval), mtick, mcarry} !== {ed, et, ec}) begin
      failures++;
      $display("FAIL %s_model got dig=%h tick=%b carry=%b want dig=%h tick=%b carry=%b",
               nm, to_bcd(mval), mtick, mcarry, ed, et, ec);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    data = v;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; chk_on = 0;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
    data = '0; dir = 1'b0;
    mval = 0; mpre = 0; mtick = 0; mcarry = 0;
    @(negedge clk);
    cyc(2);
    chk_on = 1;
    lit("reset", 16'h0000, 1'b0, 1'b0);

    rst_n = 1'b1; en = 1'b1;
    cyc(3);
    lit("pre_first_tick", 16'h0000, 1'b0, 1'b0);
    cyc(1);
    lit("first_tick", 16'h0001, 1'b1, 1'b0);

    do_load(16'h9998);
    lit("load_9998", 16'h9998, 1'b0, 1'b0);
    cyc(4);
    lit("to_9999", 16'h9999, 1'b1, 1'b0);
    cyc(4);
    lit("wrap_0000", 16'h0000, 1'b1, 1'b1);
    cyc(1);
    lit("carry_one_cycle", 16'h0000, 1'b0, 1'b0);

    do_load(16'h0129);
    cyc(4);
    lit("cascade_0130", 16'h0130, 1'b1, 1'b0);
    do_load(16'hA5F3);
    lit("load_invalid", 16'h0503, 1'b0, 1'b0);

    do_load(16'h0000);
    cyc(2);
    en = 1'b0;
    cyc(10);
    lit("hold_disabled", 16'h0000, 1'b0, 1'b0);
    en = 1'b1;
    cyc(1);
    lit("resume_one", 16'h0000, 1'b0, 1'b0);
    cyc(1);
    lit("resume_tick", 16'h0001, 1'b1, 1'b0);

    cyc(3);
    clr = 1'b1; load = 1'b1; data = 16'h1234;
    cyc(1);
    clr = 1'b0; load = 1'b0;
    lit("clr_over_load", 16'h0000, 1'b0, 1'b0);

    do_load(16'h0007);
    cyc(6);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    lit("reset_mid", 16'h0000, 1'b0, 1'b0);

    // Longer run across 0999->1000 with a gappy enable.
    do_load(16'h0995);
    for (int i = 0; i < 80; i++) begin
      en = (i % 5 != 3);
      cyc(1);
    end
    en = 1'b1;
    do_load(16'h9999);
    cyc(4);
    lit("wrap_from_load", 16'h0000, 1'b1, 1'b1);

`ifdef BCD_DOWN_EN
    dir = 1'b1;
    do_load(16'h0000);
    cyc(4);
    lit("down_wrap", 16'h9999, 1'b1, 1'b1);
    do_load(16'h1000);
    cyc(4);
    lit("down_borrow", 16'h0999, 1'b1, 1'b0);
    cyc(40);
    dir = 1'b0;
`endif

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
